tap_stability_monitor: RTL and testbench



---
 rtl/tap_stability_monitor_if.sv | 32 +++
 rtl/tap_stability_monitor.sv | 161 ++++++++++++++++
 tb/tb_tap_stability_monitor.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/tap_stability_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : tap_stability_monitor_if
// Brief    : Tap inputs, output queue handshake and status of the tap monitor.
// Revision : 1.0
// ============================================================================
interface tap_stability_monitor_if #(
    parameter int N     = 3,
    parameter int CNT_W = 8
);
    logic [N-1:0]     tap0;
    logic [N-1:0]     tap1;
    logic [N-1:0]     tap2;
    logic [N-1:0]     out_word;
    logic             out_valid;
    logic             out_ready;
    logic             locked;
    logic [CNT_W-1:0] change_cnt;
    logic             overflow;

    // master: the monitor itself; slave: tap source and word consumer
    modport master (
        input  tap0, tap1, tap2, out_ready,
        output out_word, out_valid, locked, change_cnt, overflow
    );

    modport slave (
        output tap0, tap1, tap2, out_ready,
        input  out_word, out_valid, locked, change_cnt, overflow
    );
endinterface
`default_nettype wire

// File: rtl/tap_stability_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tap_stability_monitor
// Brief    : Detects when three delay taps agree for STABLE_CYCLES clocks and
//            emits each settled word once through a 2-entry output queue.
//            Optional TSM_DEDUP_EN suppresses re-emitting the last word.
// Revision : 1.0
// ============================================================================
module tap_stability_monitor #(
    parameter int N             = 3,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic reset,
    tap_stability_monitor_if.master bus
);

    localparam int RUN_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [RUN_W-1:0] c_RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_UNSTABLE = 2'd0,
        ST_COUNTING = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_cand;
    logic [RUN_W-1:0] r_run;
    logic             r_locked;
    logic [CNT_W-1:0] r_chg;
    logic [N-1:0]     r_mem0;
    logic [N-1:0]     r_mem1;
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_count;
    logic             r_ovf;

    logic w_match;
    logic w_hold;
    logic w_lock_now;
    logic w_push;
    logic w_pop;
    logic w_full;

    assign w_match    = (bus.tap0 == bus.tap1) && (bus.tap1 == bus.tap2);
    assign w_hold     = w_match && (bus.tap2 == r_cand);
    assign w_lock_now = (r_state == ST_COUNTING) && w_hold && (r_run == c_RUN_LAST);
    assign w_pop      = (r_count != 2'd0) && bus.out_ready;
    assign w_full     = (r_count == 2'd2);

`ifdef TSM_DEDUP_EN
    logic [N-1:0] r_last_word;
    logic         r_last_vld;

    assign w_push = w_lock_now && !(r_last_vld && (r_cand == r_last_word));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_word <= '0;
            r_last_vld  <= 1'b0;
        end else if (w_push) begin
            r_last_word <= r_cand;
            r_last_vld  <= 1'b1;
        end
    end
`else
    assign w_push = w_lock_now;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_UNSTABLE;
            r_cand   <= '0;
            r_run    <= '0;
            r_locked <= 1'b0;
            r_chg    <= '0;
        end else begin
            case (r_state)
                ST_UNSTABLE: begin
                    if (w_match) begin
                        r_state <= ST_COUNTING;
                        r_cand  <= bus.tap2;
                        r_run   <= RUN_W'(1);
                    end
                end
                ST_COUNTING: begin
                    if (!w_hold) begin
                        r_state <= ST_UNSTABLE;
                        r_run   <= '0;
                    end else if (r_run == c_RUN_LAST) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                    end else begin
                        r_run <= r_run + RUN_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!w_hold) begin
                        r_state  <= ST_UNSTABLE;
                        r_run    <= '0;
                        r_locked <= 1'b0;
                        if (r_chg != c_CNT_MAX) begin
                            r_chg <= r_chg + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state  <= ST_UNSTABLE;
                    r_run    <= '0;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // A pop in the same cycle frees a slot, so a push into a full queue
    // only drops when the consumer is not taking the head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            if (w_push && (!w_full || w_pop)) begin
                if (r_wr) begin
                    r_mem1 <= r_cand;
                end else begin
                    r_mem0 <= r_cand;
                end
                r_wr <= ~r_wr;
                if (!w_pop) begin
                    r_count <= r_count + 2'd1;
                end
            end else begin
                if (w_pop) begin
                    r_count <= r_count - 2'd1;
                end
                if (w_push) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid  = (r_count != 2'd0);
    assign bus.out_word   = (r_count == 2'd0) ? '0 : (r_rd ? r_mem1 : r_mem0);
    assign bus.locked     = r_locked;
    assign bus.change_cnt = r_chg;
    assign bus.overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_tap_stability_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_tap_stability_monitor
// Brief    : Scoreboard bench for tap_stability_monitor (N=3, STABLE_CYCLES=4).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_tap_stability_monitor;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    int   exp_chg;
    logic [2:0] sb[$];

    tap_stability_monitor_if #(.N(3), .CNT_W(8)) bus ();

    tap_stability_monitor #(
        .N(3),
        .STABLE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_word: got %0d, expected no word", bus.out_word);
            end else begin
                chk("out_word", int'(bus.out_word), int'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_taps(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        bus.tap0 = a;
        bus.tap1 = b;
        bus.tap2 = c;
    endtask

    task automatic lock_on(input logic [2:0] v);
        set_taps(v, v, v);
        repeat (4) tick();
    endtask

    task automatic break_lock();
        set_taps(3'd7, 3'd0, 3'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_chg = 0;
        reset   = 1'b0;
        bus.out_ready = 1'b1;
        set_taps(3'd0, 3'd1, 3'd2);
        #2;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_change_cnt", int'(bus.change_cnt), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_out_word", int'(bus.out_word), 0);
        #1 reset = 1'b1;

        // First lock on 5, popped on the following edge
        sb.push_back(3'd5);
        set_taps(3'd5, 3'd5, 3'd5);
        repeat (3) tick();
        chk("lock5_not_yet", int'(bus.locked), 0);
        tick();
        chk("lock5_locked", int'(bus.locked), 1);
        chk("lock5_valid", int'(bus.out_valid), 1);
        chk("lock5_word", int'(bus.out_word), 5);
        tick();
        chk("lock5_popped", int'(bus.out_valid), 0);
        set_taps(3'd5, 3'd5, 3'd0);
        tick();
        exp_chg = 1;
        chk("lose5_locked", int'(bus.locked), 0);
        chk("lose5_chg", int'(bus.change_cnt), exp_chg);

        // Glitch mid-count restarts the run
        set_taps(3'd2, 3'd2, 3'd2);
        repeat (3) tick();
        set_taps(3'd6, 3'd2, 3'd2);
        tick();
        chk("glitch_locked", int'(bus.locked), 0);
        set_taps(3'd2, 3'd2, 3'd2);
        repeat (3) tick();
        chk("restart_3clk", int'(bus.locked), 0);
        sb.push_back(3'd2);
        tick();
        chk("restart_locked", int'(bus.locked), 1);

        // Taps move to a new agreed value: lock lost, then relock
        sb.push_back(3'd3);
        set_taps(3'd3, 3'd3, 3'd3);
        tick();
        exp_chg = 2;
        chk("move3_locked", int'(bus.locked), 0);
        chk("move3_chg", int'(bus.change_cnt), exp_chg);
        repeat (4) tick();
        chk("move3_relock", int'(bus.locked), 1);
        tick();

        // Stalled consumer: third word overflows
        bus.out_ready = 1'b0;
        break_lock();
        sb.push_back(3'd1);
        lock_on(3'd1);
        break_lock();
        sb.push_back(3'd2);
        lock_on(3'd2);
        chk("full_no_ovf", int'(bus.overflow), 0);
        break_lock();
        lock_on(3'd3);
        exp_chg = 5;
        chk("ovf_set", int'(bus.overflow), 1);
        chk("ovf_valid", int'(bus.out_valid), 1);
        chk("ovf_head_stable", int'(bus.out_word), 1);
        chk("ovf_chg", int'(bus.change_cnt), exp_chg);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("drain_empty", int'(bus.out_valid), 0);
        chk("ovf_sticky", int'(bus.overflow), 1);

        // Clean restart, then relock to the same value twice
        set_taps(3'd7, 3'd0, 3'd0);
        reset = 1'b0;
        sb.delete();
        #1 reset = 1'b1;
        sb.push_back(3'd4);
        lock_on(3'd4);
        break_lock();
`ifndef TSM_DEDUP_EN
        sb.push_back(3'd4);
`endif
        lock_on(3'd4);
        chk("relock4_locked", int'(bus.locked), 1);
        chk("relock4_chg", int'(bus.change_cnt), 1);
        repeat (2) tick();
        chk("relock4_all_emitted", sb.size(), 0);
        chk("relock4_empty", int'(bus.out_valid), 0);

        // Reset mid-count with one word queued and overflow set
        bus.out_ready = 1'b0;
        break_lock();
        sb.push_back(3'd1);
        lock_on(3'd1);
        break_lock();
        sb.push_back(3'd2);
        lock_on(3'd2);
        break_lock();
        lock_on(3'd3);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        break_lock();
        set_taps(3'd5, 3'd5, 3'd5);
        repeat (2) tick();
        chk("pre_rst_valid", int'(bus.out_valid), 1);
        chk("pre_rst_ovf", int'(bus.overflow), 1);
        chk("pre_rst_word", int'(bus.out_word), 2);
        reset = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_valid", int'(bus.out_valid), 0);
        chk("async_rst_locked", int'(bus.locked), 0);
        chk("async_rst_ovf", int'(bus.overflow), 0);
        chk("async_rst_chg", int'(bus.change_cnt), 0);
        chk("async_rst_word", int'(bus.out_word), 0);
        #1 reset = 1'b1;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
